// File: rtl/piso_shiftregister_if.sv
// Load handshake and serial-output bundle for piso_shiftregister.
// master = word source / link side, slave = the shift register itself.
interface piso_shiftregister_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sdo;
    logic             sdo_valid;
    logic             sdo_last;
    logic             busy;

    modport master (
        output din, load_valid, shift_en,
        input  load_ready, sdo, sdo_valid, sdo_last, busy
    );

    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, sdo, sdo_valid, sdo_last, busy
    );
endinterface

// File: rtl/piso_shiftregister.sv
// PISO transmitter: WIDTH-bit word out LSB first, framed by sdo_valid/sdo_last; PISO_PARITY_EN appends even parity.
// Latency: first bit on sdo one clock after the load transfer; each bit held until a shift_en tick.
// Backpressure: load_ready only in IDLE or on the final bit's tick, giving gap-free back-to-back frames.
module piso_shiftregister #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    piso_shiftregister_if.slave  bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;

    logic w_shifting;
    logic w_last;
    logic w_tick;
    logic w_xfer;
    logic w_fill;

`ifdef PISO_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_par <= 1'b0;
        end else if (w_xfer) begin
            r_par <= ^bus.din;
        end
    end

    // Parity enters at the top so it lands on sreg[0] right after din[WIDTH-1].
    assign w_fill = r_par;
`else
    assign w_fill = 1'b0;
`endif

    assign w_shifting = (r_state == S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == LAST_CNT);
    assign w_tick     = w_shifting && bus.shift_en;
    assign w_xfer     = bus.load_valid && bus.load_ready;

    assign bus.load_ready = !w_shifting || (w_last && bus.shift_en);
    assign bus.sdo        = r_sreg[0];
    assign bus.sdo_valid  = w_shifting;
    assign bus.busy       = w_shifting;
    assign bus.sdo_last   = w_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            r_state <= S_SHIFT;
            r_sreg  <= bus.din;
            r_cnt   <= '0;
        end else if (w_tick) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_sreg <= {w_fill, r_sreg[WIDTH-1:1]};
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_shiftregister.sv
// Bench for piso_shiftregister (default build and PISO_PARITY_EN build).
module tb_piso_shiftregister;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   timeout;

    logic rec_vld[$], rec_sdo[$], rec_last[$], rec_rdy[$], rec_en[$], rec_busy[$];
    int   xfer_cyc[$];
    logic exp_bits[$];

    piso_shiftregister_if #(.WIDTH(W)) bus ();
    piso_shiftregister #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // Reference: each word becomes its bits LSB first, then even parity when enabled.
    task automatic model_frames(input word_t words[$]);
        exp_bits.delete();
        foreach (words[i]) begin
            for (int b = 0; b < W; b++) exp_bits.push_back(words[i][b]);
            if (FL > W) exp_bits.push_back(^words[i]);
        end
    endtask

    // Offers words in order and records one output sample per cycle.
    // period 0 = random shift_en, else shift_en on every period-th cycle.
    task automatic run(input word_t words[$], input int period, input bit gaps, input int budget);
        int wi;
        int hold;
        bit got;
        wi = 0;
        hold = 0;
        timeout = 0;
        rec_vld.delete(); rec_sdo.delete(); rec_last.delete();
        rec_rdy.delete(); rec_en.delete(); rec_busy.delete(); xfer_cyc.delete();
        for (int cyc = 0; cyc <= budget; cyc++) begin
            if (cyc == budget) begin
                timeout = 1;
                break;
            end
            bus.load_valid = (wi < words.size()) && (hold == 0);
            bus.din        = bus.load_valid ? words[wi] : word_t'($urandom);
            bus.shift_en   = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
            #1;
            rec_vld.push_back(bus.sdo_valid);
            rec_sdo.push_back(bus.sdo);
            rec_last.push_back(bus.sdo_last);
            rec_rdy.push_back(bus.load_ready);
            rec_en.push_back(bus.shift_en);
            rec_busy.push_back(bus.busy);
            got = bus.load_valid && bus.load_ready;
            if (got) begin
                xfer_cyc.push_back(cyc);
                wi++;
                hold = gaps ? int'($urandom_range(0, 3)) : 0;
            end else if (hold > 0) begin
                hold--;
            end
            if (wi == words.size() && !got && !bus.sdo_valid) break;
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
        bus.shift_en   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.load_valid = 1'b1; bus.din = 4'hF; bus.shift_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.sdo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_valid got=%b exp=0", bus.sdo_valid); end
        n_tests++; if (bus.sdo_last !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_last got=%b exp=0", bus.sdo_last); end
        n_tests++; if (bus.sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got=%b exp=0", bus.sdo); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        clr = 1'b0; bus.load_valid = 1'b0; bus.shift_en = 1'b0;
        #1;
        n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++; if (bus.sdo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_frame cyc=%0d got=%b exp=0", i, bus.sdo_valid); end
        end
    endtask

    task automatic test_single();
        word_t ws[$] = '{4'b1011};
        int first, nv, k;
        word_t q;
        first = -1; nv = 0; k = 0; q = '0;
        run(ws, 1, 1'b0, 40);
        model_frames(ws);
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=%b exp=0", timeout); end
        foreach (rec_vld[c]) begin
            if (rec_vld[c]) begin
                if (first < 0) first = c;
                nv++;
                n_tests++; if (k >= exp_bits.size() || rec_sdo[c] !== exp_bits[k]) begin n_fail++; $display("FAIL single_bit k=%0d got=%b", k, rec_sdo[c]); end
                n_tests++; if (rec_last[c] !== (k == FL - 1)) begin n_fail++; $display("FAIL single_last k=%0d got=%b exp=%b", k, rec_last[c], k == FL - 1); end
                if (k < W) q = {rec_sdo[c], q[W-1:1]};
                k++;
            end
        end
        n_tests++; if (nv != FL) begin n_fail++; $display("FAIL single_valid_cycles got=%0d exp=%0d", nv, FL); end
        n_tests++; if (xfer_cyc.size() < 1 || first != xfer_cyc[0] + 1) begin n_fail++; $display("FAIL single_latency first=%0d xfers=%0d", first, xfer_cyc.size()); end
        n_tests++; if (q !== 4'b1011) begin n_fail++; $display("FAIL single_sipo got=%b exp=1011", q); end
    endtask

    task automatic test_paced();
        word_t ws[$] = '{4'b1011};
        int nv, k, held, nrdy, rdy_at, lastv;
        nv = 0; k = 0; held = 0; nrdy = 0; rdy_at = -1; lastv = -1;
        run(ws, 3, 1'b0, 80);
        model_frames(ws);
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL paced_timeout got=%b exp=0", timeout); end
        foreach (rec_vld[c]) begin
            if (rec_vld[c]) begin
                nv++;
                lastv = c;
                held++;
                if (rec_rdy[c]) begin nrdy++; rdy_at = c; end
                if (rec_en[c]) begin
                    n_tests++; if (held != 3) begin n_fail++; $display("FAIL paced_hold k=%0d got=%0d exp=3", k, held); end
                    n_tests++; if (k >= exp_bits.size() || rec_sdo[c] !== exp_bits[k]) begin n_fail++; $display("FAIL paced_bit k=%0d got=%b", k, rec_sdo[c]); end
                    held = 0;
                    k++;
                end
            end
        end
        n_tests++; if (nv != 3 * FL) begin n_fail++; $display("FAIL paced_busy_cycles got=%0d exp=%0d", nv, 3 * FL); end
        n_tests++; if (nrdy != 1 || rdy_at != lastv) begin n_fail++; $display("FAIL paced_ready got=%0d at=%0d exp=1 at=%0d", nrdy, rdy_at, lastv); end
    endtask

    task automatic test_back_to_back();
        word_t ws[$] = '{4'hA, 4'h5};
        int nv, k, first, lastv;
        nv = 0; k = 0; first = -1; lastv = -1;
        run(ws, 1, 1'b0, 60);
        model_frames(ws);
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got=%b exp=0", timeout); end
        foreach (rec_vld[c]) begin
            if (rec_vld[c]) begin
                if (first < 0) first = c;
                lastv = c;
                nv++;
                n_tests++; if (k >= exp_bits.size() || rec_sdo[c] !== exp_bits[k]) begin n_fail++; $display("FAIL b2b_bit k=%0d got=%b", k, rec_sdo[c]); end
                n_tests++; if (rec_last[c] !== ((k % FL) == FL - 1)) begin n_fail++; $display("FAIL b2b_last k=%0d got=%b", k, rec_last[c]); end
                k++;
            end
        end
        n_tests++; if (nv != 2 * FL || lastv - first + 1 != nv) begin n_fail++; $display("FAIL b2b_contiguous got=%0d span=%0d exp=%0d", nv, lastv - first + 1, 2 * FL); end
        n_tests++; if (xfer_cyc.size() != 2 || xfer_cyc[1] - xfer_cyc[0] != FL) begin n_fail++; $display("FAIL b2b_reload xfers=%0d exp gap=%0d", xfer_cyc.size(), FL); end
    endtask

    task automatic test_mid_reset();
        word_t ws[$] = '{4'h3};
        int nv, k;
        nv = 0; k = 0;
        bus.din = 4'hC; bus.load_valid = 1'b1; bus.shift_en = 1'b1;
        #1;
        n_tests++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.load_ready); end
        @(posedge clk); #1;
        bus.load_valid = 1'b0; bus.din = 4'hF;
        n_tests++; if (bus.sdo_valid !== 1'b1 || bus.sdo !== 1'b0) begin n_fail++; $display("FAIL midrst_bit0 got=%b%b exp=10", bus.sdo_valid, bus.sdo); end
        @(posedge clk); #1;
        n_tests++; if (bus.sdo !== 1'b0) begin n_fail++; $display("FAIL midrst_bit1 got=%b exp=0", bus.sdo); end
        @(posedge clk); #1;
        n_tests++; if (bus.sdo !== 1'b1) begin n_fail++; $display("FAIL midrst_bit2 got=%b exp=1", bus.sdo); end
        clr = 1'b1; bus.load_valid = 1'b1; bus.din = 4'hF;
        @(posedge clk); #1;
        clr = 1'b0; bus.load_valid = 1'b0;
        n_tests++; if (bus.sdo_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sdo_last !== 1'b0) begin n_fail++; $display("FAIL midrst_abort got=%b%b%b exp=000", bus.sdo_valid, bus.busy, bus.sdo_last); end
        @(posedge clk); #1;
        n_tests++; if (bus.sdo_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dropped got=%b exp=0", bus.sdo_valid); end
        run(ws, 1, 1'b0, 40);
        model_frames(ws);
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout got=%b exp=0", timeout); end
        foreach (rec_vld[c]) begin
            if (rec_vld[c]) begin
                nv++;
                n_tests++; if (k >= exp_bits.size() || rec_sdo[c] !== exp_bits[k]) begin n_fail++; $display("FAIL midrst_next_bit k=%0d got=%b", k, rec_sdo[c]); end
                k++;
            end
        end
        n_tests++; if (nv != FL) begin n_fail++; $display("FAIL midrst_next_len got=%0d exp=%0d", nv, FL); end
    endtask

    task automatic test_random();
        word_t ws[$];
        int n, k, nx;
        bit ev, el, er;
        for (int it = 0; it < 4; it++) begin
            ws.delete();
            n = int'($urandom_range(2, 5));
            k = 0; nx = 0;
            for (int i = 0; i < n; i++) ws.push_back(word_t'($urandom));
            run(ws, 0, 1'b1, 400);
            model_frames(ws);
            n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rand_timeout it=%0d got=%b exp=0", it, timeout); end
            foreach (rec_vld[c]) begin
                while (nx < xfer_cyc.size() && xfer_cyc[nx] < c) nx++;
                ev = (nx * FL > k);
                el = ev && ((k % FL) == FL - 1);
                er = !ev || (el && rec_en[c]);
                n_tests++; if (rec_vld[c] !== ev) begin n_fail++; $display("FAIL rand_valid it=%0d c=%0d got=%b exp=%b", it, c, rec_vld[c], ev); end
                n_tests++; if (rec_busy[c] !== ev) begin n_fail++; $display("FAIL rand_busy it=%0d c=%0d got=%b exp=%b", it, c, rec_busy[c], ev); end
                n_tests++; if (rec_last[c] !== el) begin n_fail++; $display("FAIL rand_last it=%0d c=%0d got=%b exp=%b", it, c, rec_last[c], el); end
                n_tests++; if (rec_rdy[c] !== er) begin n_fail++; $display("FAIL rand_ready it=%0d c=%0d got=%b exp=%b", it, c, rec_rdy[c], er); end
                if (ev) begin
                    n_tests++; if (k >= exp_bits.size() || rec_sdo[c] !== exp_bits[k]) begin n_fail++; $display("FAIL rand_bit it=%0d k=%0d got=%b", it, k, rec_sdo[c]); end
                    if (rec_en[c]) k++;
                end
            end
            n_tests++; if (k != n * FL || xfer_cyc.size() != n) begin n_fail++; $display("FAIL rand_count it=%0d bits=%0d xfers=%0d exp=%0d/%0d", it, k, xfer_cyc.size(), n * FL, n); end
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        word_t ws[$];
        logic [4:0] obs, lastm;
        int k;
        for (int t = 0; t < 2; t++) begin
            ws.delete();
            ws.push_back(t == 0 ? 4'b0111 : 4'b0011);
            obs = '0; lastm = '0; k = 0;
            run(ws, 1, 1'b0, 40);
            n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL parity_timeout t=%0d got=%b exp=0", t, timeout); end
            foreach (rec_vld[c]) begin
                if (rec_vld[c] && k < 5) begin
                    obs[k] = rec_sdo[c];
                    lastm[k] = rec_last[c];
                    k++;
                end
            end
            n_tests++; if (obs !== (t == 0 ? 5'b10111 : 5'b00011)) begin n_fail++; $display("FAIL parity_bits t=%0d got=%b", t, obs); end
            n_tests++; if (lastm !== 5'b10000 || k != 5) begin n_fail++; $display("FAIL parity_last t=%0d got=%b len=%0d exp=10000 len=5", t, lastm, k); end
        end
    endtask
`endif

    initial begin
        bus.din = '0;
        bus.load_valid = 1'b0;
        bus.shift_en = 1'b0;
        test_reset();
        test_single();
        test_paced();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
